product_accumulator: RTL

- Downstream stage of the fixed-latency pipelined multiplier; consumes its product stream and sums products into frame results (dot-product / MAC use).
- The multiplier carries no valid or stall. This block therefore tracks a valid/last tag through its own DELAY-deep shift register, so each tag lines up with its product.
- Delivers each frame sum on a valid/ready output register.

---
 rtl/product_accumulator.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// product_accumulator
// Sums the product stream of a fixed-latency pipelined multiplier into frame
// results. The multiplier has no valid or stall, so a {valid, last} tag is
// carried through a local DELAY-deep shift register and meets its product at
// stage DELAY-1. Each frame sum is delivered on a valid/ready output register.
//
// Optional build macro: PRODUCT_ACCUMULATOR_SAT_EN
//   undefined: the accumulator wraps modulo 2^ACC_WIDTH; ovf reports a wrap.
//   defined:   the accumulator saturates to 2^ACC_WIDTH-1 for the rest of the
//              frame; ovf reports saturation.
//
// state  | meaning
// IDLE   | no partial frame; acc holds zero
// ACCUM  | at least one term of the current frame has been summed into acc

module product_accumulator #(
    parameter int WIDTH_P   = 10,
    parameter int ACC_WIDTH = 24,
    parameter int DELAY     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [WIDTH_P-1:0]   product,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 overrun,
    output logic                 ovf
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic                 frame_carry;

    logic [DELAY-1:0]     tag_valid;
    logic [DELAY-1:0]     tag_last;
    logic                 tv;
    logic                 tl;

    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH:0]   sum_ext;
    logic                 carry;
    logic [ACC_WIDTH-1:0] sum_val;
    logic                 sum_ovf;

    logic                 deliver;
    logic [ACC_WIDTH-1:0] result;
    logic                 result_ovf;

    // Tag pipe: in_last is qualified by in_valid on entry so a stray last
    // without valid can never close a frame.
    generate
        if (DELAY == 1) begin : g_tag_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_valid <= '0;
                    tag_last  <= '0;
                end else begin
                    tag_valid[0] <= in_valid;
                    tag_last[0]  <= in_valid & in_last;
                end
            end
        end else begin : g_tag_shift
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_valid <= '0;
                    tag_last  <= '0;
                end else begin
                    tag_valid <= {tag_valid[DELAY-2:0], in_valid};
                    tag_last  <= {tag_last[DELAY-2:0], in_valid & in_last};
                end
            end
        end
    endgenerate

    assign tv = tag_valid[DELAY-1];
    assign tl = tag_last[DELAY-1];

    assign prod_ext = ACC_WIDTH'(product);

    // Running sum of acc and the aligned product, with the frame's overflow status.
    always_comb begin
        sum_ext = {1'b0, acc} + {1'b0, prod_ext};
        carry   = sum_ext[ACC_WIDTH];
        sum_ovf = frame_carry | carry;
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
        // Once a frame has saturated it stays pinned at full scale.
        if (sum_ovf) begin
            sum_val = '1;
        end else begin
            sum_val = sum_ext[ACC_WIDTH-1:0];
        end
`else
        sum_val = sum_ext[ACC_WIDTH-1:0];
`endif
    end

    // Result selection for the edge that closes a frame.
    always_comb begin
        deliver    = 1'b0;
        result     = '0;
        result_ovf = 1'b0;
        if (tv && tl) begin
            deliver = 1'b1;
            if (state == IDLE) begin
                // Single-term frame: product always fits since ACC_WIDTH >= WIDTH_P.
                result     = prod_ext;
                result_ovf = 1'b0;
            end else begin
                result     = sum_val;
                result_ovf = sum_ovf;
            end
        end
    end

    // Frame FSM: accumulates aligned products; bubbles (!tv) hold everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            frame_carry <= 1'b0;
        end else if (tv) begin
            case (state)
                IDLE: begin
                    if (!tl) begin
                        acc         <= prod_ext;
                        frame_carry <= 1'b0;
                        state       <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (tl) begin
                        acc         <= '0;
                        frame_carry <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        acc         <= sum_val;
                        frame_carry <= sum_ovf;
                    end
                end
                default: begin
                    acc         <= '0;
                    frame_carry <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Output register: a new result wins over a same-edge transfer, and
    // replacing an unconsumed result flags a sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out   <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (deliver) begin
                acc_out   <= result;
                ovf       <= result_ovf;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state == ACCUM) || (|tag_valid);

endmodule
